// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg -- shared definitions for the LED dimmer (led_sterownik).
//   * default parameter constants for counter width, debounce length, fade step
//   * fade FSM state enum
//   * granica(): target duty for a brightness level 0..3
// -----------------------------------------------------------------------------
package led_pkg;

    localparam int ROZMIAR_LICZNIKA_DOMYSLNY = 16;
    localparam int DEBOUNCE_CYKLE_DOMYSLNE   = 100000;
    localparam int KROK_FADE_DOMYSLNY        = 256;

    typedef enum logic [1:0] {
        STOJ   = 2'd0,   // duty == target
        ROSNIJ = 2'd1,   // duty <  target
        MALEJ  = 2'd2    // duty >  target
    } stan_fade_e;

    // Target duty for level n: floor(0.1 * 10**(n/3) * 2**szerokosc) for n = 0..2,
    // full-on 2**szerokosc for n = 3. The irrational factors are held as
    // 32-bit binary fractions; their truncation error is far below one LSB of
    // the result for any practical counter width.
    function automatic logic [63:0] granica(input logic [1:0] poziom, input int szerokosc);
        logic [63:0] wsp;
        case (poziom)
            2'd0:    wsp = 64'd429496729;    // 0.1          * 2**32
            2'd1:    wsp = 64'd925322653;    // 0.1*10**(1/3) * 2**32
            2'd2:    wsp = 64'd1993547224;   // 0.1*10**(2/3) * 2**32
            default: wsp = 64'd0;
        endcase
        if (poziom == 2'd3) begin
            granica = 64'd1 << szerokosc;
        end else begin
            granica = (wsp << szerokosc) >> 32;
        end
    endfunction

endpackage

// File: rtl/led_sterownik_if.sv
// -----------------------------------------------------------------------------
// led_sterownik_if -- button inputs and LED/status outputs of the dimmer.
//   in_przycisk_gora / in_przycisk_dol : raw asynchronous buttons, active high
//   out_led    : registered PWM drive
//   out_poziom : selected brightness level 0..3
//   out_zajety : high while the duty is fading toward its target
// master = whoever drives the buttons, slave = the dimmer.
// -----------------------------------------------------------------------------
interface led_sterownik_if;
    logic       in_przycisk_gora;
    logic       in_przycisk_dol;
    logic       out_led;
    logic [1:0] out_poziom;
    logic       out_zajety;

    modport master (
        output in_przycisk_gora, in_przycisk_dol,
        input  out_led, out_poziom, out_zajety
    );

    modport slave (
        input  in_przycisk_gora, in_przycisk_dol,
        output out_led, out_poziom, out_zajety
    );
endinterface

// File: rtl/led_debounce.sv
// -----------------------------------------------------------------------------
// led_debounce -- 2-flop synchronizer, stability counter and press-edge pulse
// for one raw button.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   przycisk_i  : raw asynchronous button level
//   puls_o      : one-cycle pulse on each accepted 0->1 transition
// -----------------------------------------------------------------------------
module led_debounce #(
    parameter int DEBOUNCE_CYKLE = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic przycisk_i,
    output logic puls_o
);

    localparam int SZER = $clog2(DEBOUNCE_CYKLE + 1);
    localparam logic [SZER-1:0] OSTATNI = SZER'(DEBOUNCE_CYKLE - 1);

    logic [1:0]      synchro_q;
    logic            stabilny_q;
    logic [SZER-1:0] licznik_q;
    logic            puls_q;
    logic            probka;

    assign probka = synchro_q[1];
    assign puls_o = puls_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            synchro_q  <= '0;
            stabilny_q <= 1'b0;
            licznik_q  <= '0;
            puls_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values;
            // the synchronizer chain would collapse to one stage with '='.
            synchro_q <= {synchro_q[0], przycisk_i};
            puls_q    <= 1'b0;
            if (probka == stabilny_q) begin
                // Any sample agreeing with the accepted level restarts the count.
                licznik_q <= '0;
            end else if (licznik_q == OSTATNI) begin
                licznik_q  <= '0;
                stabilny_q <= probka;
                puls_q     <= probka;   // presses pulse, releases do not
            end else begin
                licznik_q <= licznik_q + SZER'(1);
            end
        end
    end

endmodule

// File: rtl/led_sterownik.sv
// -----------------------------------------------------------------------------
// led_sterownik -- three-step LED dimmer with PWM output and linear fading.
//   in_clk, in_rst_n : system clock, asynchronous active-low reset
//   bus (slave)      : buttons in, out_led / out_poziom / out_zajety out
// Two debounced buttons step a level 0..3; each level maps to a target duty.
// The duty walks toward the target by at most KROK_FADE per PWM period.
// -----------------------------------------------------------------------------
module led_sterownik
    import led_pkg::*;
#(
    parameter int ROZMIAR_LICZNIKA = ROZMIAR_LICZNIKA_DOMYSLNY,
    parameter int DEBOUNCE_CYKLE   = DEBOUNCE_CYKLE_DOMYSLNE,
    parameter int KROK_FADE        = KROK_FADE_DOMYSLNY
) (
    input logic           in_clk,
    input logic           in_rst_n,
    led_sterownik_if.slave bus
);

    localparam int W = ROZMIAR_LICZNIKA;

    // One bit wider than the counter so full-on (2**W) is representable.
    typedef logic [W:0] duty_t;

    localparam duty_t KROK      = duty_t'(KROK_FADE);
    localparam duty_t GRANICA_0 = duty_t'(granica(2'd0, W));

    logic [W-1:0] licznik_q;
    logic         led_q;
    logic [1:0]   poziom_q, poziom_d;
    duty_t        duty_q, duty_d;
    duty_t        cel, cel_poprz_q, roznica;
    stan_fade_e   stan_q, stan_d;
    logic         puls_gora, puls_dol;
    logic         zawiniecie;

    led_debounce #(.DEBOUNCE_CYKLE(DEBOUNCE_CYKLE)) u_gora (
        .clk        (in_clk),
        .rst_n      (in_rst_n),
        .przycisk_i (bus.in_przycisk_gora),
        .puls_o     (puls_gora)
    );

    led_debounce #(.DEBOUNCE_CYKLE(DEBOUNCE_CYKLE)) u_dol (
        .clk        (in_clk),
        .rst_n      (in_rst_n),
        .przycisk_i (bus.in_przycisk_dol),
        .puls_o     (puls_dol)
    );

    assign zawiniecie = &licznik_q;
    assign cel        = duty_t'(granica(poziom_q, W));

    // Level stepping; simultaneous up and down cancel each other.
    always_comb begin
        // NOTE: default first so no path leaves poziom_d unassigned (no latch).
        poziom_d = poziom_q;
        if (puls_gora && !puls_dol && poziom_q != 2'd3) begin
            poziom_d = poziom_q + 2'd1;
        end else if (puls_dol && !puls_gora && poziom_q != 2'd0) begin
            poziom_d = poziom_q - 2'd1;
        end
    end

    // Fade step. The wrap-cycle step uses the target as it stood in the previous
    // cycle (cel_poprz_q), so a retarget landing on the wrap only acts at the
    // next wrap. The state is then re-derived from the new duty against the
    // current target: this gives STOJ exactly when duty arrives, and a
    // ROSNIJ<->MALEJ swap one clock after a reversing press, without a duty jump.
    always_comb begin
        duty_d  = duty_q;
        roznica = '0;
        if (zawiniecie) begin
            case (stan_q)
                ROSNIJ: begin
                    roznica = cel_poprz_q - duty_q;
                    duty_d  = duty_q + ((roznica > KROK) ? KROK : roznica);
                end
                MALEJ: begin
                    roznica = duty_q - cel_poprz_q;
                    duty_d  = duty_q - ((roznica > KROK) ? KROK : roznica);
                end
                default: ;
            endcase
        end
        if (duty_d < cel) begin
            stan_d = ROSNIJ;
        end else if (duty_d > cel) begin
            stan_d = MALEJ;
        end else begin
            stan_d = STOJ;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            licznik_q   <= '0;
            led_q       <= 1'b0;
            poziom_q    <= 2'd0;
            duty_q      <= GRANICA_0;
            cel_poprz_q <= GRANICA_0;
            stan_q      <= STOJ;
        end else begin
            licznik_q   <= licznik_q + W'(1);
            // Zero-extended compare: duty 2**W exceeds every count, so full-on is solid.
            led_q       <= ({1'b0, licznik_q} < duty_q);
            poziom_q    <= poziom_d;
            duty_q      <= duty_d;
            cel_poprz_q <= cel;
            stan_q      <= stan_d;
        end
    end

    assign bus.out_led    = led_q;
    assign bus.out_poziom = poziom_q;
    assign bus.out_zajety = (stan_q != STOJ);

endmodule

// File: tb/tb_led_sterownik.sv
// -----------------------------------------------------------------------------
// tb_led_sterownik -- directed bench for led_sterownik with
// ROZMIAR_LICZNIKA=8, DEBOUNCE_CYKLE=4, KROK_FADE=16.
// Level targets at this width: 25, 55, 118, 256.
// -----------------------------------------------------------------------------
module tb_led_sterownik;
    import led_pkg::*;

    localparam int W     = 8;
    localparam int N     = 4;
    localparam int K     = 16;
    localparam int OKRES = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    led_sterownik_if bus ();

    led_sterownik #(
        .ROZMIAR_LICZNIKA (W),
        .DEBOUNCE_CYKLE   (N),
        .KROK_FADE        (K)
    ) dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int cykl = 0;
    always @(posedge clk) cykl <= cykl + 1;

    int n_testow = 0;
    int n_bledow = 0;

    typedef struct {
        logic gora;
        logic dol;
        int   exp_poziom;
    } wektor_t;

    wektor_t tab[10];

    task automatic check(input string nazwa, input int aktualna, input int wymagana);
        n_testow++;
        if (aktualna != wymagana) begin
            n_bledow++;
            $display("FAIL %s: got %0d, expected %0d", nazwa, aktualna, wymagana);
        end
    endtask

    task automatic nacisnij(input logic gora, input logic dol, input int trwanie, input int przerwa);
        @(negedge clk);
        bus.in_przycisk_gora = gora;
        bus.in_przycisk_dol  = dol;
        repeat (trwanie) @(negedge clk);
        bus.in_przycisk_gora = 1'b0;
        bus.in_przycisk_dol  = 1'b0;
        repeat (przerwa) @(negedge clk);
    endtask

    task automatic policz_led(output int ile);
        ile = 0;
        repeat (OKRES) begin
            @(negedge clk);
            if (bus.out_led) ile++;
        end
    endtask

    task automatic czekaj_na_duty(input string nazwa, output int nowa, output int odstep);
        int  stara;
        int  start;
        bit  ok;
        stara = int'(dut.duty_q);
        start = cykl;
        ok    = 1'b0;
        for (int i = 0; i < 2 * OKRES; i++) begin
            @(negedge clk);
            if (int'(dut.duty_q) != stara) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_testow++;
            n_bledow++;
            $display("FAIL %s: duty stuck at %0d, expected a change within %0d clocks", nazwa, stara, 2 * OKRES);
        end
        nowa   = int'(dut.duty_q);
        odstep = cykl - start;
    endtask

    task automatic czekaj_stoj(input string nazwa, input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!bus.out_zajety) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_testow++;
            n_bledow++;
            $display("FAIL %s: out_zajety still 1 after %0d clocks, expected 0", nazwa, limit);
        end
    endtask

    task automatic do_poczatku_okresu();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2 * OKRES; i++) begin
            @(negedge clk);
            if (dut.licznik_q == '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_testow++;
            n_bledow++;
            $display("FAIL counter_wrap: counter never reached 0, expected within %0d clocks", 2 * OKRES);
        end
    endtask

    initial begin
        int ile;
        int duty;
        int odstep;

        tab[0] = '{1'b1, 1'b0, 2};
        tab[1] = '{1'b1, 1'b1, 2};
        tab[2] = '{1'b0, 1'b1, 1};
        tab[3] = '{1'b0, 1'b1, 0};
        tab[4] = '{1'b0, 1'b1, 0};
        tab[5] = '{1'b1, 1'b1, 0};
        tab[6] = '{1'b1, 1'b0, 1};
        tab[7] = '{1'b1, 1'b0, 2};
        tab[8] = '{1'b1, 1'b0, 3};
        tab[9] = '{1'b1, 1'b0, 3};

        bus.in_przycisk_gora = 1'b0;
        bus.in_przycisk_dol  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_led",    int'(bus.out_led),    0);
        check("reset_poziom", int'(bus.out_poziom), 0);
        check("reset_zajety", int'(bus.out_zajety), 0);
        check("reset_duty",   int'(dut.duty_q),     25);
        rst_n = 1'b1;

        // Idle PWM at level 0
        policz_led(ile);
        check("idle_led_high_count", ile, 25);
        check("idle_poziom", int'(bus.out_poziom), 0);
        check("idle_zajety", int'(bus.out_zajety), 0);

        // Single up press, fade 25 -> 41 -> 55
        do_poczatku_okresu();
        nacisnij(1'b1, 1'b0, 10, 2);
        check("up1_poziom", int'(bus.out_poziom), 1);
        check("up1_zajety", int'(bus.out_zajety), 1);
        check("up1_duty_before_wrap", int'(dut.duty_q), 25);
        czekaj_na_duty("up1_wrap1", duty, odstep);
        check("up1_duty_wrap1", duty, 41);
        check("up1_zajety_wrap1", int'(bus.out_zajety), 1);
        czekaj_na_duty("up1_wrap2", duty, odstep);
        check("up1_duty_wrap2", duty, 55);
        check("up1_wrap_interval", odstep, OKRES);
        check("up1_zajety_wrap2", int'(bus.out_zajety), 0);
        policz_led(ile);
        check("lvl1_led_high_count", ile, 55);

        // Bouncing input never holds 4 stable samples
        repeat (4) nacisnij(1'b1, 1'b0, 1, 1);
        nacisnij(1'b1, 1'b0, 3, 10);
        check("bounce_poziom", int'(bus.out_poziom), 1);
        check("bounce_duty",   int'(dut.duty_q),     55);
        check("bounce_zajety", int'(bus.out_zajety), 0);

        // Fade 55 -> 118 reversed by a down press at duty 87
        nacisnij(1'b1, 1'b0, 10, 2);
        czekaj_na_duty("rev_wrap1", duty, odstep);
        check("rev_duty_71", duty, 71);
        czekaj_na_duty("rev_wrap2", duty, odstep);
        check("rev_duty_87", duty, 87);
        nacisnij(1'b0, 1'b1, 10, 2);
        check("rev_poziom", int'(bus.out_poziom), 1);
        check("rev_stan_malej", int'(dut.stan_q), int'(MALEJ));
        check("rev_no_jump", int'(dut.duty_q), 87);
        check("rev_zajety", int'(bus.out_zajety), 1);
        czekaj_na_duty("rev_wrap3", duty, odstep);
        check("rev_duty_down_71", duty, 71);
        czekaj_na_duty("rev_wrap4", duty, odstep);
        check("rev_duty_down_55", duty, 55);
        check("rev_zajety_end", int'(bus.out_zajety), 0);

        // Level stepping table: saturation and simultaneous presses
        for (int i = 0; i < 10; i++) begin
            nacisnij(tab[i].gora, tab[i].dol, 10, 10);
            check($sformatf("tab%0d_poziom", i), int'(bus.out_poziom), tab[i].exp_poziom);
        end

        // Full-on after reaching level 3
        czekaj_stoj("full_settle", 40 * OKRES);
        check("full_duty", int'(dut.duty_q), 256);
        policz_led(ile);
        check("full_led_high_count", ile, OKRES);
        check("full_poziom", int'(bus.out_poziom), 3);

        // Reset in the middle of a fade at duty 87
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nacisnij(1'b1, 1'b0, 10, 2);
        czekaj_stoj("rst_settle", 4 * OKRES);
        check("rst_pre_duty", int'(dut.duty_q), 55);
        nacisnij(1'b1, 1'b0, 10, 2);
        czekaj_na_duty("rst_wrap1", duty, odstep);
        czekaj_na_duty("rst_wrap2", duty, odstep);
        check("rst_pre_duty_87", duty, 87);
        #2 rst_n = 1'b0;
        #1;
        check("rst_led",    int'(bus.out_led),    0);
        check("rst_duty",   int'(dut.duty_q),     25);
        check("rst_poziom", int'(bus.out_poziom), 0);
        check("rst_zajety", int'(bus.out_zajety), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_release_poziom", int'(bus.out_poziom), 0);
        check("rst_release_zajety", int'(bus.out_zajety), 0);

        $display("[TB] %0d tests run, %0d failed", n_testow, n_bledow);
        $finish;
    end

endmodule

// File: doc/led_sterownik.md
LED_STEROWNIK -- requirements
Module: led_sterownik

Interface
REQ-001 Parameter ROZMIAR_LICZNIKA, default 16, SHALL set the PWM counter width; the PWM period is 2**ROZMIAR_LICZNIKA clocks.
REQ-002 Parameter DEBOUNCE_CYKLE, default 100000, SHALL set the number of clocks a synchronized button level must hold stable before it is accepted (10 ms at 10 MHz).
REQ-003 Parameter KROK_FADE, default 256, SHALL set the maximum duty change per PWM period.
REQ-004 in_clk  input  1  SHALL be the single system clock.
REQ-005 in_rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 in_przycisk_gora  input  1  SHALL be the raw, asynchronous, active-high brightness-up button.
REQ-007 in_przycisk_dol  input  1  SHALL be the raw, asynchronous, active-high brightness-down button.
REQ-008 out_led  output  1  SHALL be the registered PWM drive to the LED.
REQ-009 out_poziom  output  2  SHALL be the selected brightness level, 0..3.
REQ-010 out_zajety  output  1  SHALL be high while the duty is fading toward its target.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer, then a debouncer that updates its accepted level only after DEBOUNCE_CYKLE consecutive equal samples.
REQ-012 A 0->1 transition of an accepted level SHALL produce a one-cycle press pulse; releases SHALL produce nothing.
REQ-013 An up pulse SHALL increment out_poziom, saturating at 3; a down pulse SHALL decrement it, saturating at 0.
REQ-014 Up and down pulses in the same cycle SHALL both be ignored.
REQ-015 The target duty SHALL be granica(out_poziom) = floor(0.1 * 10**(n/3) * 2**ROZMIAR_LICZNIKA) for n = 0..2, and 2**ROZMIAR_LICZNIKA for n = 3.
REQ-016 Default-width targets SHALL be 6553, 14119, 30419 and 65536; targets for ROZMIAR_LICZNIKA=8 SHALL be 25, 55, 118 and 256.
REQ-017 Duty and target SHALL be ROZMIAR_LICZNIKA+1 bits wide so that the full-on value is representable.
REQ-018 The counter SHALL increment every clock and wrap from all-ones to 0.
REQ-019 out_led SHALL be registered as (counter < duty), giving exactly one clock of latency; duty = 2**ROZMIAR_LICZNIKA SHALL drive a constant 1.
REQ-020 The fade FSM SHALL have three states: STOJ (duty == target), ROSNIJ (duty < target) and MALEJ (duty > target).
REQ-021 In STOJ, a target change SHALL move the FSM to ROSNIJ or MALEJ on the next clock.
REQ-022 In ROSNIJ or MALEJ, duty SHALL change only in the cycle where the counter wraps, by min(KROK_FADE, |target - duty|) toward the target.
REQ-023 When duty reaches the target, the FSM SHALL enter STOJ.
REQ-024 A press during a fade SHALL retarget immediately; the FSM SHALL switch ROSNIJ<->MALEJ at the next clock if the direction reverses, with no duty jump.
REQ-025 A target change landing exactly in the wrap cycle SHALL take effect at the next wrap, never in the same cycle.
REQ-026 out_zajety SHALL equal (state != STOJ).

Reset
REQ-027 While in_rst_n is low, the block SHALL hold: counter 0, out_led 0, out_poziom 0, duty = target = granica(0), state STOJ, synchronizer and debouncer flops 0, out_zajety 0.
REQ-028 Reset mid-fade SHALL abandon the fade and restart from REQ-027 values, with no press pulse generated on release of reset.

Structure
REQ-029 Package led_pkg SHALL hold the fade-state enum, the granica() function and the default parameter constants.
REQ-030 The debouncer SHALL be one sub-module, led_debounce (synchronizer, stability counter and edge pulse), instantiated once per button.

Verification
Bench parameters: ROZMIAR_LICZNIKA=8, DEBOUNCE_CYKLE=4, KROK_FADE=16.
REQ-031 Release reset with no buttons pressed -> out_led high for 25 of every 256 clocks, out_poziom=0, out_zajety=0.
REQ-032 Press up for 10 clocks -> out_poziom=1, out_zajety=1; duty is 41 after the first wrap and 55 after the second; out_zajety drops on the second wrap.
REQ-033 Bounce up with 1-clock glitches (fewer than 4 stable clocks) -> out_poziom unchanged, no pulse.
REQ-034 Four up presses from level 0 -> out_poziom=3, duty ramps to 256 and out_led is constant 1; a fifth press leaves out_poziom=3.
REQ-035 Assert up and down simultaneously -> no level change; press down during a fade from 55 toward 118 -> FSM goes to MALEJ and duty returns toward 55 in 16-step wraps.
REQ-036 Assert reset mid-fade at duty 87 -> out_led=0 immediately, duty=25, out_poziom=0, out_zajety=0.
